// File: rtl/dff.sv
// ---------------------------------------------------------------------------
// dff -- WIDTH-bit D flip-flop with complementary outputs.
//
// Leaf storage cell for control/status bits, pipeline flags and test
// structures. Every bit shares one clock, one synchronous set and one
// asynchronous reset.
//
// Ports (positional order is fixed because existing instantiations
// connect by position):
//   q      out  [WIDTH]  stored value
//   qbar   out  [WIDTH]  bitwise complement of q
//   d      in   [WIDTH]  data captured on the rising edge of clk
//   set    in   1        synchronous, active-low; loads all-ones at an edge
//   reset  in   1        asynchronous, active-low; clears q immediately
//   clk    in   1        clock, rising-edge active
//
// Priority: reset > set > d.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dff #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    input  logic [WIDTH-1:0] d,
    input  logic             set,
    input  logic             reset,
    input  logic             clk
);

    // Single state register; qbar is derived from it so the two outputs
    // can never disagree.
    logic [WIDTH-1:0] r_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its inputs before any of them update on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (!set) begin
            // The set mux sits in front of D, so this maps onto a plain
            // async-clear flop with no async-set pin.
            r_q <= '1;
        end else begin
            r_q <= d;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule

// File: tb/tb_dff.sv
// ---------------------------------------------------------------------------
// tb_dff -- self-checking bench for dff.
//
// Directed steps follow the timeline of a 10-unit clock (rising edges at
// 5, 15, 25, ...), then a randomized phase compares the DUT against a
// behavioural model of the storage rules kept in the bench.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dff;

    localparam int W = 4;
    localparam logic [W-1:0] ONES  = '1;
    localparam logic [W-1:0] ZEROS = '0;

    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic [W-1:0] d;
    logic         set;
    logic         reset;
    logic         clk;

    int n_checks = 0;
    int n_fail   = 0;

    dff #(.WIDTH(W)) u_dut (
        .q     (q),
        .qbar  (qbar),
        .d     (d),
        .set   (set),
        .reset (reset),
        .clk   (clk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute-time stepping for the directed timeline.
    task automatic at(input longint t);
        if ($time < t) #(t - $time);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks both outputs against one expected stored value.
    task automatic check_q(input string tag, input logic [W-1:0] exp);
        check({tag, ".q"}, q, exp);
        check({tag, ".qbar"}, qbar, ~exp);
    endtask

    // Reference model: what a rising edge stores, straight from the rules
    // "reset wins, then set loads all-ones, otherwise d".
    function automatic logic [W-1:0] edge_value(input logic [W-1:0] cur,
                                                input logic [W-1:0] din,
                                                input logic set_n,
                                                input logic rst_n);
        logic [W-1:0] v;
        v = cur;
        if (rst_n == 1'b0)     v = ZEROS;
        else if (set_n == 1'b0) v = ONES;
        else                    v = din;
        return v;
    endfunction

    initial begin
        logic [W-1:0] exp_q;

        // Power-up: idle controls, first edge at t=5 loads d=0.
        set   = 1'b1;
        reset = 1'b1;
        d     = ZEROS;
        at(6);
        check_q("first_edge", ZEROS);

        // Synchronous set overrides d, even when d drops while set is low.
        at(7);  set = 1'b0; d = ONES;
        at(12); d = ZEROS;
        at(16); check_q("sync_set", ONES);

        // Release set, load data.
        at(22); set = 1'b1; d = ZEROS;
        at(26); check_q("load_zero", ZEROS);
        at(42); d = ONES;
        at(46); check_q("load_ones", ONES);

        // Asynchronous reset acts with no clock edge.
        at(47); reset = 1'b0;
        at(48); check_q("async_reset", ZEROS);
        at(54); d = ONES; set = 1'b1;
        at(56); check_q("reset_holds", ZEROS);

        // Release between edges: no capture until the next rising edge.
        at(59); reset = 1'b1;
        at(60); check_q("release_no_capture", ZEROS);
        at(66); check_q("first_edge_after_release", ONES);
        d = ZEROS;
        at(76); check_q("load_after_release", ZEROS);

        // Reset beats set across an edge.
        at(82); set = 1'b0; reset = 1'b0;
        at(86); check_q("reset_over_set", ZEROS);
        at(88); set = 1'b1; reset = 1'b1; d = ONES;
        at(96); check_q("reload_ones", ONES);

        // A set pulse wholly between edges is invisible.
        d = 4'b1010;
        at(97);  set = 1'b0;
        at(100); set = 1'b1;
        at(101); check_q("short_set_between_edges", ONES);
        at(106); check_q("short_set_ignored", 4'b1010);

        // Randomized phase: inputs change just after the falling edge, the
        // model tracks async reset immediately and everything else per edge.
        exp_q = 4'b1010;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            d     = W'($urandom);
            set   = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 9) != 0);
            #1;
            if (!reset) exp_q = ZEROS;
            check_q("rand_mid", exp_q);
            @(posedge clk);
            #1;
            exp_q = edge_value(exp_q, d, set, reset);
            check_q("rand_edge", exp_q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Stimulus is purely time-driven; this only guards against a runaway.
    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
